mips_mc_control: RTL and testbench

Multicycle sequencing controller for the single-memory MIPS datapath. It issues every datapath strobe (PC write, IR write, memory access, register write, mux selects, ALU class) one state at a time, so a single ALU and one memory port serve fetch, address, and execute work across 3–5 cycles per instruction. It sits beside the register file, ALU and shared memory in the multicycle processor top and reads only the opcode field of the instruction register.

---
 rtl/mips_mc_control_pkg.sv | 89 ++++++++
 rtl/mips_mc_control_if.sv | 37 +++
 rtl/mips_mc_control_opcode_class.sv | 21 ++
 rtl/mips_mc_control.sv | 96 +++++++++
 tb/tb_mips_mc_control.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/mips_mc_control_pkg.sv
// mips_mc_pkg: state, opcode-class and strobe encodings plus the per-state strobe decode for the multicycle controller
package mips_mc_pkg;

    localparam int MEM_WAIT_MAX = 15;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_IMM   = 2'b11;

    localparam logic [1:0] SRCB_B   = 2'b00;
    localparam logic [1:0] SRCB_4   = 2'b01;
    localparam logic [1:0] SRCB_SE  = 2'b10;
    localparam logic [1:0] SRCB_SE2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
        S_EXEC, S_R_WB, S_I_EXEC, S_I_WB, S_BRANCH, S_JUMP, S_TRAP
    } state_t;

    typedef enum logic [2:0] {
        CL_RTYPE, CL_LOAD, CL_STORE, CL_IALU, CL_BRANCH, CL_JUMP, CL_ILLEGAL
    } op_class_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_sel;
        logic [1:0] pc_src;
        logic       instr_done;
        logic       illegal;
    } ctrl_t;

    // Moore strobes for a state; FETCH carries ir_write/pc_write unconditionally and the top gates them
    function automatic ctrl_t ctrl_decode(input state_t s, input logic [5:0] op);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH:    begin c.mem_read = 1'b1; c.alu_src_b = SRCB_4; c.ir_write = 1'b1; c.pc_write = 1'b1; end
            S_DECODE:   c.alu_src_b = SRCB_SE2;
            S_MEM_ADDR: begin c.alu_src_a = 1'b1; c.alu_src_b = SRCB_SE; end
            S_MEM_RD:   begin c.mem_read = 1'b1; c.i_or_d = 1'b1; end
            S_MEM_WB:   begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; c.instr_done = 1'b1; end
            S_MEM_WR:   begin c.mem_write = 1'b1; c.i_or_d = 1'b1; c.instr_done = 1'b1; end
            S_EXEC:     begin c.alu_src_a = 1'b1; c.alu_sel = ALU_FUNCT; end
            S_R_WB:     begin c.reg_write = 1'b1; c.reg_dst = 1'b1; c.instr_done = 1'b1; end
            S_I_EXEC:   begin c.alu_src_a = 1'b1; c.alu_src_b = SRCB_SE; c.alu_sel = ALU_IMM; end
            S_I_WB:     begin c.reg_write = 1'b1; c.instr_done = 1'b1; end
            S_BRANCH:   begin
                c.alu_src_a     = 1'b1;
                c.alu_sel       = ALU_SUB;
                c.pc_src        = PCSRC_ALUOUT;
                c.pc_write_cond = 1'b1;
                c.branch_ne     = (op == OP_BNE);
                c.instr_done    = 1'b1;
            end
            S_JUMP:     begin c.pc_src = PCSRC_JUMP; c.pc_write = 1'b1; c.instr_done = 1'b1; end
            S_TRAP:     begin c.illegal = 1'b1; c.instr_done = 1'b1; end
            default:    c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mips_mc_control_if.sv
// mips_mc_control_if: opcode/memory handshake in, datapath strobes out; master = controller, slave = datapath
interface mips_mc_control_if;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_sel;
    logic [1:0] pc_src;
    logic       instr_done;
    logic       illegal;
    logic       mem_timeout;
    logic [3:0] state;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write, ir_write,
               reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_sel, pc_src,
               instr_done, illegal, mem_timeout, state
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write, ir_write,
               reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_sel, pc_src,
               instr_done, illegal, mem_timeout, state
    );
endinterface

// File: rtl/mips_mc_control_opcode_class.sv
// mc_opcode_class: maps the IR opcode field to the instruction class used for dispatch
module mc_opcode_class
    import mips_mc_pkg::*;
(
    input  logic [5:0] i_opcode,
    output op_class_t  o_class
);
    // pure opcode lookup; anything unrecognised is illegal
    always_comb begin
        o_class = CL_ILLEGAL;
        case (i_opcode)
            OP_RTYPE:                         o_class = CL_RTYPE;
            OP_LW:                            o_class = CL_LOAD;
            OP_SW:                            o_class = CL_STORE;
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: o_class = CL_IALU;
            OP_BEQ, OP_BNE:                   o_class = CL_BRANCH;
            OP_J:                             o_class = CL_JUMP;
            default:                          o_class = CL_ILLEGAL;
        endcase
    end
endmodule

// File: rtl/mips_mc_control.sv
// mips_mc_control: multicycle MIPS sequencer; define MC_MEM_WAIT_EN to stall memory states on mem_ready with timeout
module mips_mc_control
    import mips_mc_pkg::*;
(
    input logic               clk,
    input logic               reset,
    mips_mc_control_if.master bus
);
    state_t    r_state;
    state_t    w_next;
    ctrl_t     r_ctrl;
    op_class_t w_class;
    logic      r_timeout;
    logic      w_ready;
    logic      w_expire;

    mc_opcode_class u_class (.i_opcode(bus.opcode), .o_class(w_class));

`ifdef MC_MEM_WAIT_EN
    logic [3:0] r_wait;
    logic       w_mem_state;
    assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
    assign w_ready     = bus.mem_ready || !w_mem_state;
    assign w_expire    = !w_ready && (r_wait == 4'(MEM_WAIT_MAX - 1));
`else
    logic w_unused;
    assign w_unused = bus.mem_ready;
    assign w_ready  = 1'b1;
    assign w_expire = 1'b0;
`endif

    // next-state: memory states hold while not ready, a wait timeout overrides everything with TRAP
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     w_next = S_FETCH;
            S_FETCH:    w_next = w_ready ? S_DECODE : S_FETCH;
            S_DECODE:   begin
                case (w_class)
                    CL_RTYPE:           w_next = S_EXEC;
                    CL_LOAD, CL_STORE:  w_next = S_MEM_ADDR;
                    CL_IALU:            w_next = S_I_EXEC;
                    CL_BRANCH:          w_next = S_BRANCH;
                    CL_JUMP:            w_next = S_JUMP;
                    default:            w_next = S_TRAP;
                endcase
            end
            S_MEM_ADDR: w_next = (w_class == CL_STORE) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   w_next = w_ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WR:   w_next = w_ready ? S_FETCH : S_MEM_WR;
            S_EXEC:     w_next = S_R_WB;
            S_I_EXEC:   w_next = S_I_WB;
            default:    w_next = S_FETCH;
        endcase
        if (w_expire) w_next = S_TRAP;
    end

    // state and strobes registered together so every strobe is a clean Moore output of the new state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_ctrl    <= '0;
            r_timeout <= 1'b0;
`ifdef MC_MEM_WAIT_EN
            r_wait    <= '0;
`endif
        end else begin
            r_state   <= w_next;
            r_ctrl    <= ctrl_decode(w_next, bus.opcode);
            r_timeout <= r_timeout || w_expire;
`ifdef MC_MEM_WAIT_EN
            r_wait    <= (w_next == r_state) ? r_wait + 4'd1 : 4'd0;
`endif
        end
    end

    // w_ready is low only in a stalled memory state, so it holds back FETCH writes and the sw completion pulse
    assign bus.pc_write      = r_ctrl.pc_write && w_ready;
    assign bus.ir_write      = r_ctrl.ir_write && w_ready;
    assign bus.instr_done    = r_ctrl.instr_done && w_ready;
    assign bus.pc_write_cond = r_ctrl.pc_write_cond;
    assign bus.branch_ne     = r_ctrl.branch_ne;
    assign bus.i_or_d        = r_ctrl.i_or_d;
    assign bus.mem_read      = r_ctrl.mem_read;
    assign bus.mem_write     = r_ctrl.mem_write;
    assign bus.reg_write     = r_ctrl.reg_write;
    assign bus.reg_dst       = r_ctrl.reg_dst;
    assign bus.mem_to_reg    = r_ctrl.mem_to_reg;
    assign bus.alu_src_a     = r_ctrl.alu_src_a;
    assign bus.alu_src_b     = r_ctrl.alu_src_b;
    assign bus.alu_sel       = r_ctrl.alu_sel;
    assign bus.pc_src        = r_ctrl.pc_src;
    assign bus.illegal       = r_ctrl.illegal;
    assign bus.mem_timeout   = r_timeout;
    assign bus.state         = r_state;
endmodule

// File: tb/tb_mips_mc_control.sv
// tb_mips_mc_control: scoreboard bench for mips_mc_control (wait-state cases run when MC_MEM_WAIT_EN is defined)
module tb_mips_mc_control;
    localparam int IDLE = 0, FETCH = 1, DECODE = 2, MEM_ADDR = 3, MEM_RD = 4, MEM_WB = 5, MEM_WR = 6;
    localparam int EXEC = 7, R_WB = 8, I_EXEC = 9, I_WB = 10, BRANCH = 11, JUMP = 12, TRAP = 13;

    typedef struct {
        string       tag;
        int          st;
        logic [19:0] v;
        logic        rdy;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_total = 0;
    int   n_bad = 0;
    exp_t q[$];

    mips_mc_control_if bus();

    mips_mc_control dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] cv(input logic pcw, pcwc, bne, iord, mr, mw, irw, rw, rd, m2r, sa,
                                        input logic [1:0] sb, sel, ps, input logic done, ill, to);
        return {pcw, pcwc, bne, iord, mr, mw, irw, rw, rd, m2r, sa, sb, sel, ps, done, ill, to};
    endfunction

    function automatic logic [19:0] obs();
        return {bus.pc_write, bus.pc_write_cond, bus.branch_ne, bus.i_or_d, bus.mem_read, bus.mem_write,
                bus.ir_write, bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.alu_src_a, bus.alu_src_b,
                bus.alu_sel, bus.pc_src, bus.instr_done, bus.illegal, bus.mem_timeout};
    endfunction

    task automatic push(input string tag, input int st, input logic [19:0] v, input logic rdy);
        exp_t e;
        e.tag = tag; e.st = st; e.v = v; e.rdy = rdy;
        q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        int   k;
        k = 0;
        while (q.size() > 0) begin
            e = q.pop_front();
            @(negedge clk);
            bus.mem_ready = e.rdy;
            #1;
            check($sformatf("%s.c%0d.state", e.tag, k), 32'(bus.state), 32'(e.st));
            check($sformatf("%s.c%0d.ctl", e.tag, k), 32'(obs()), 32'(e.v));
            k++;
        end
    endtask

    task automatic run(input string nm, input logic [5:0] op, input int fs, input int ms, input logic to);
        bus.opcode = op;
        repeat (fs) push(nm, FETCH, cv(0,0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0,0,to), 1'b0);
        push(nm, FETCH,  cv(1,0,0,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,0,0,to), 1'b1);
        push(nm, DECODE, cv(0,0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,0,to), 1'b1);
        case (op)
            6'b000000: begin
                push(nm, EXEC, cv(0,0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0,0,to), 1'b1);
                push(nm, R_WB, cv(0,0,0,0,0,0,0,1,1,0,0,2'b00,2'b00,2'b00,1,0,to), 1'b1);
            end
            6'b100011: begin
                push(nm, MEM_ADDR, cv(0,0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0,to), 1'b1);
                repeat (ms) push(nm, MEM_RD, cv(0,0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0,to), 1'b0);
                push(nm, MEM_RD, cv(0,0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0,to), 1'b1);
                push(nm, MEM_WB, cv(0,0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,1,0,to), 1'b1);
            end
            6'b101011: begin
                push(nm, MEM_ADDR, cv(0,0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0,to), 1'b1);
                repeat (ms) push(nm, MEM_WR, cv(0,0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,0,to), 1'b0);
                push(nm, MEM_WR, cv(0,0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,1,0,to), 1'b1);
            end
            6'b001000, 6'b001100, 6'b001101, 6'b001010: begin
                push(nm, I_EXEC, cv(0,0,0,0,0,0,0,0,0,0,1,2'b10,2'b11,2'b00,0,0,to), 1'b1);
                push(nm, I_WB,   cv(0,0,0,0,0,0,0,1,0,0,0,2'b00,2'b00,2'b00,1,0,to), 1'b1);
            end
            6'b000100, 6'b000101:
                push(nm, BRANCH, cv(0,1,op[0],0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,1,0,to), 1'b1);
            6'b000010:
                push(nm, JUMP, cv(1,0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,1,0,to), 1'b1);
            default:
                push(nm, TRAP, cv(0,0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,1,1,to), 1'b1);
        endcase
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.opcode    = 6'b0;
        bus.mem_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            check("rst.state", 32'(bus.state), IDLE);
            check("rst.ctl", 32'(obs()), 32'h0);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rel.state", 32'(bus.state), IDLE);

        run("lw",   6'b100011, 0, 0, 1'b0);
        run("sw",   6'b101011, 0, 0, 1'b0);
        run("add",  6'b000000, 0, 0, 1'b0);
        run("addi", 6'b001000, 0, 0, 1'b0);
        run("andi", 6'b001100, 0, 0, 1'b0);
        run("ori",  6'b001101, 0, 0, 1'b0);
        run("slti", 6'b001010, 0, 0, 1'b0);
        run("beq",  6'b000100, 0, 0, 1'b0);
        run("bne",  6'b000101, 0, 0, 1'b0);
        run("j",    6'b000010, 0, 0, 1'b0);
        run("ill",  6'b111111, 0, 0, 1'b0);
        run("ill2", 6'b100000, 0, 0, 1'b0);

        // reset lands in the MEM_RD cycle of a load: must drop to IDLE at once with no register write
        bus.opcode = 6'b100011;
        push("lwrst", FETCH,    cv(1,0,0,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,0,0,0), 1'b1);
        push("lwrst", DECODE,   cv(0,0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,0,0), 1'b1);
        push("lwrst", MEM_ADDR, cv(0,0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0,0), 1'b1);
        push("lwrst", MEM_RD,   cv(0,0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0,0), 1'b1);
        drain();
        reset = 1'b0;
        #1;
        check("midrst.state", 32'(bus.state), IDLE);
        check("midrst.ctl", 32'(obs()), 32'h0);
        @(negedge clk);
        #1;
        check("midrst.reg_write", 32'(bus.reg_write), 32'h0);
        reset = 1'b1;
        #1;
        check("midrst.rel", 32'(bus.state), IDLE);
        run("after", 6'b000000, 0, 0, 1'b0);

`ifdef MC_MEM_WAIT_EN
        run("lw_w", 6'b100011, 1, 2, 1'b0);
        run("sw_w", 6'b101011, 0, 2, 1'b0);
        run("sw_w0", 6'b101011, 2, 0, 1'b0);

        // store whose memory never answers: 15 wait cycles, then TRAP with the sticky flag
        bus.opcode = 6'b101011;
        push("to", FETCH,    cv(1,0,0,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,0,0,0), 1'b1);
        push("to", DECODE,   cv(0,0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,0,0), 1'b1);
        push("to", MEM_ADDR, cv(0,0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0,0), 1'b1);
        repeat (15) push("to", MEM_WR, cv(0,0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,0,0), 1'b0);
        push("to", TRAP,     cv(0,0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,1,1,1), 1'b0);
        drain();
        run("sticky", 6'b000010, 0, 0, 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
